// File: rtl/code_counter_pkg.sv
// Shared defaults, count type and prescaler-width helper for the dual event counter.
package code_counter_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_DIV   = 4;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

    // A DIV of 1 or 2 still needs a one-bit prescaler register.
    function automatic int pcnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/code_dual_counter_if.sv
// Select/enable inputs and the two count outputs of the dual event counter.
interface code_dual_counter_if #(parameter int WIDTH = 64);

    logic             Slt;
    logic             En;
    logic [WIDTH-1:0] Output0;
    logic [WIDTH-1:0] Output1;

    modport master (output Slt, output En, input Output0, input Output1);
    modport slave  (input Slt, input En, output Output0, output Output1);

endinterface

// File: rtl/code_prescaler.sv
// Divide-by-DIV prescaler; wrap_o strobes on the enabled tick that wraps pcnt back to zero.
module code_prescaler
    import code_counter_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic Clk,
    input  logic Reset,
    input  logic tick_en,
    output logic wrap_o
);

    localparam int PW = pcnt_width(DIV);

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic          at_top;

    assign at_top = (pcnt_q == PW'(DIV - 1));
    assign wrap_o = tick_en & at_top;

    always_comb begin
        pcnt_d = pcnt_q;
        if (tick_en) begin
            pcnt_d = at_top ? '0 : pcnt_q + PW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/code_dual_counter.sv
// Dual event counter: channel 0 counts every enabled Slt=0 cycle, channel 1 every DIV-th Slt=1 cycle.
// Define CODE_COUNTER_SATURATE_EN to make both counters stick at all-ones instead of wrapping.
module code_dual_counter
    import code_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV   = DEFAULT_DIV
) (
    input  logic                Clk,
    input  logic                Reset,
    code_dual_counter_if.slave  bus
);

    logic [WIDTH-1:0] out0_q;
    logic [WIDTH-1:0] out0_d;
    logic [WIDTH-1:0] out1_q;
    logic [WIDTH-1:0] out1_d;
    logic             p_wrap;

    function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] v);
`ifdef CODE_COUNTER_SATURATE_EN
        return (v == '1) ? v : v + WIDTH'(1);
`else
        return v + WIDTH'(1);
`endif
    endfunction

    // The prescaler keeps cycling even when Output1 is saturated.
    code_prescaler #(.DIV(DIV)) u_prescaler (
        .Clk     (Clk),
        .Reset   (Reset),
        .tick_en (bus.En & bus.Slt),
        .wrap_o  (p_wrap)
    );

    always_comb begin
        out0_d = out0_q;
        out1_d = out1_q;
        if (bus.En && !bus.Slt) begin
            out0_d = bump(out0_q);
        end
        if (p_wrap) begin
            out1_d = bump(out1_q);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            out0_q <= '0;
            out1_q <= '0;
        end else begin
            out0_q <= out0_d;
            out1_q <= out1_d;
        end
    end

    assign bus.Output0 = out0_q;
    assign bus.Output1 = out1_q;

endmodule

// File: tb/tb_code_dual_counter.sv
// Scoreboard bench: a 64-bit DIV=4 counter and a 4-bit DIV=1 counter driven from the same stimulus.
module tb_code_dual_counter;
    import code_counter_pkg::*;

    localparam int DIV_B = 4;
    localparam int DIV_S = 1;

    typedef struct packed {
        logic [63:0] b0;
        logic [63:0] b1;
        logic [3:0]  s0;
        logic [3:0]  s1;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    code_dual_counter_if #(.WIDTH(64)) if_big ();
    code_dual_counter_if #(.WIDTH(4))  if_small ();

    code_dual_counter #(.WIDTH(64), .DIV(DIV_B)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (if_big)
    );

    code_dual_counter #(.WIDTH(4), .DIV(DIV_S)) dut_small (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (if_small)
    );

    exp_t   sb_q[$];
    int     checks = 0;
    int     errors = 0;

    count_t      m0, m1;
    int          mp;
    logic [3:0]  n0, n1;
    int          np;

    function automatic logic [63:0] inc64(input logic [63:0] v);
`ifdef CODE_COUNTER_SATURATE_EN
        return (v == '1) ? v : v + 64'd1;
`else
        return v + 64'd1;
`endif
    endfunction

    function automatic logic [3:0] inc4(input logic [3:0] v);
`ifdef CODE_COUNTER_SATURATE_EN
        return (v == 4'hF) ? v : v + 4'd1;
`else
        return v + 4'd1;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the expected post-edge state goes to the scoreboard.
    task automatic step(input logic rst, input logic en, input logic slt);
        @(negedge Clk);
        Reset = rst;
        if_big.En = en;
        if_big.Slt = slt;
        if_small.En = en;
        if_small.Slt = slt;
        if (!rst) begin
            m0 = '0; m1 = '0; mp = 0;
            n0 = '0; n1 = '0; np = 0;
        end else if (en) begin
            if (!slt) begin
                m0 = inc64(m0);
                n0 = inc4(n0);
            end else begin
                if (mp == DIV_B - 1) begin m1 = inc64(m1); mp = 0; end
                else mp++;
                if (np == DIV_S - 1) begin n1 = inc4(n1); np = 0; end
                else np++;
            end
        end
        sb_q.push_back('{b0: m0, b1: m1, s0: n0, s1: n1});
        @(posedge Clk);
        #2;
    endtask

    // Monitor: outputs are registered, so every edge with a pending entry is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("big_out0",   if_big.Output0,   e.b0);
                chk("big_out1",   if_big.Output1,   e.b1);
                chk("small_out0", {60'd0, if_small.Output0}, {60'd0, e.s0});
                chk("small_out1", {60'd0, if_small.Output1}, {60'd0, e.s1});
            end
        end
    end

    initial begin
        if_big.En = 1'b0;  if_big.Slt = 1'b0;
        if_small.En = 1'b0; if_small.Slt = 1'b0;

        // Reset wins over enable with Slt toggling
        step(0, 1, 0);
        chk("rst_out0", if_big.Output0, 64'd0);
        step(0, 1, 1);
        chk("rst_out1", if_big.Output1, 64'd0);

        step(1, 1, 0);
        chk("first_count", if_big.Output0, 64'd1);

        for (int i = 0; i < 10; i++) step(1, 1, 0);
        chk("ch0_run", if_big.Output0, 64'd11);
        chk("ch0_run_o1", if_big.Output1, 64'd0);

        for (int i = 1; i <= 9; i++) begin
            step(1, 1, 1);
            if (i == 3) chk("presc_e3", if_big.Output1, 64'd0);
            if (i == 4) chk("presc_e4", if_big.Output1, 64'd1);
            if (i == 8) chk("presc_e8", if_big.Output1, 64'd2);
        end
        chk("presc_e9", if_big.Output1, 64'd2);
        chk("presc_o0", if_big.Output0, 64'd11);

        // Prescaler progress survives interleaved Slt=0 cycles
        step(0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 1);
        step(1, 1, 0);
        step(1, 1, 0);
        chk("retain_pre", if_big.Output1, 64'd0);
        step(1, 1, 1);
        chk("retain_o1", if_big.Output1, 64'd1);
        chk("retain_o0", if_big.Output0, 64'd2);

        // En=0 freezes everything, including pcnt
        step(1, 1, 1);
        step(1, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 0, i[0]);
        chk("freeze_o0", if_big.Output0, 64'd2);
        chk("freeze_o1", if_big.Output1, 64'd1);
        step(1, 1, 1);
        chk("resume_pre", if_big.Output1, 64'd1);
        step(1, 1, 1);
        chk("resume_o1", if_big.Output1, 64'd2);

        // Channel-0 wrap/saturate on the 4-bit instance
        step(0, 1, 0);
        for (int i = 0; i < 15; i++) step(1, 1, 0);
        chk("small_full", {60'd0, if_small.Output0}, 64'd15);
        step(1, 1, 0);
`ifdef CODE_COUNTER_SATURATE_EN
        chk("small_edge", {60'd0, if_small.Output0}, 64'd15);
`else
        chk("small_edge", {60'd0, if_small.Output0}, 64'd0);
`endif
        chk("big_16", if_big.Output0, 64'd16);

        for (int i = 0; i < 3; i++) step(1, 1, 1);
        chk("div1_o1", {60'd0, if_small.Output1}, 64'd3);

        #3;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
